// File: rtl/y86_alu_if.sv
// y86_alu_if: operand/function inputs and registered result/flags of the Execute-stage ALU
interface y86_alu_if #(parameter int WIDTH = 64);
   logic [WIDTH-1:0] aluA;
   logic [WIDTH-1:0] aluB;
   logic [3:0]       alufun;
   logic             cf;
   logic             zf;
   logic             sf;
   logic             of;
   logic [WIDTH-1:0] valE;
   modport master (output aluA, aluB, alufun, input cf, zf, sf, of, valE);
   modport slave (input aluA, aluB, alufun, output cf, zf, sf, of, valE);
endinterface

// File: rtl/y86_alu.sv
// y86_alu: registered 64-bit Y86-64 Execute-stage ALU producing valE and CF/ZF/SF/OF
module y86_alu #(parameter int WIDTH = 64) (
   input logic clk,
   input logic rst,
   y86_alu_if.slave bus
);
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [5:0]       sh;
   logic [WIDTH-1:0] r;
   logic             c;
   logic             o;
   logic             sa;
   logic             sb;
   assign sum = {1'b0, bus.aluB} + {1'b0, bus.aluA};
   assign dif = {1'b0, bus.aluB} - {1'b0, bus.aluA};
   assign sh  = bus.aluA[5:0];
   assign sa  = bus.aluA[WIDTH-1];
   assign sb  = bus.aluB[WIDTH-1];
   // result mux and carry/overflow; bit WIDTH of dif is the borrow, codes 8..15 pass aluB
   always_comb begin
      r = bus.alufun == 4'd0 ? dif[WIDTH-1:0] :
          bus.alufun == 4'd1 ? sum[WIDTH-1:0] :
          bus.alufun == 4'd2 ? bus.aluA & bus.aluB :
          bus.alufun == 4'd3 ? bus.aluA ^ bus.aluB :
          bus.alufun == 4'd4 ? bus.aluA | bus.aluB :
          bus.alufun == 4'd5 ? bus.aluB << sh :
          bus.alufun == 4'd6 ? bus.aluB >> sh :
          bus.alufun == 4'd7 ? WIDTH'($signed(bus.aluB) >>> sh) :
          bus.aluB;
      c = bus.alufun == 4'd0 ? dif[WIDTH] :
          bus.alufun == 4'd1 ? sum[WIDTH] : 1'b0;
      o = bus.alufun == 4'd0 ? (sa != sb) && (dif[WIDTH-1] != sb) :
          bus.alufun == 4'd1 ? (sa == sb) && (sum[WIDTH-1] != sa) : 1'b0;
   end
   // register result and flags every cycle; reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.valE <= '0;
         bus.cf   <= 1'b0;
         bus.zf   <= 1'b0;
         bus.sf   <= 1'b0;
         bus.of   <= 1'b0;
      end else begin
         bus.valE <= r;
         bus.cf   <= c;
         bus.zf   <= r == '0;
         bus.sf   <= r[WIDTH-1];
         bus.of   <= o;
      end
   end
endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: directed-vector self-checking bench for y86_alu
module tb_y86_alu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   y86_alu_if #(.WIDTH(64)) bus ();
   y86_alu #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                      input logic [63:0] ev, input logic [3:0] ef);
      bus.aluA = a;
      bus.aluB = b;
      bus.alufun = f;
      @(posedge clk);
      #1;
      check({tag, "_valE"}, bus.valE, ev);
      check({tag, "_czso"}, {60'd0, bus.cf, bus.zf, bus.sf, bus.of}, {60'd0, ef});
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      bus.aluA = 64'd5;
      bus.aluB = 64'd7;
      bus.alufun = 4'd1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valE", bus.valE, 64'd0);
      check("reset_czso", {60'd0, bus.cf, bus.zf, bus.sf, bus.of}, 64'd0);
      rst = 1'b0;
      run("rel_add", 64'd5, 64'd7, 4'd1, 64'd12, 4'b0000);
      run("add_wrap", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 64'd0, 4'b1100);
      run("add_stack", 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 4'd1, 64'hF8, 4'b1000);
      run("sub_ovf", 64'd1, 64'h8000_0000_0000_0000, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001);
      run("sub_borrow", 64'd2, 64'd1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);
      run("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd1, 64'h8000_0000_0000_0000, 4'b0011);
      run("and", 64'hF0F0, 64'h0F0F, 4'd2, 64'd0, 4'b0100);
      run("xor", 64'hF0F0, 64'h0F0F, 4'd3, 64'hFFFF, 4'b0000);
      run("or", 64'hF0F0, 64'h0F0F, 4'd4, 64'hFFFF, 4'b0000);
      run("shl", 64'd4, 64'h8000_0000_0000_0010, 4'd5, 64'h100, 4'b0000);
      run("shr", 64'd4, 64'h8000_0000_0000_0010, 4'd6, 64'h0800_0000_0000_0001, 4'b0000);
      run("sar", 64'd4, 64'h8000_0000_0000_0010, 4'd7, 64'hF800_0000_0000_0001, 4'b0010);
      run("shl_mask", 64'h44, 64'h8000_0000_0000_0010, 4'd5, 64'h100, 4'b0000);
      run("sar_zero", 64'h40, 64'h8000_0000_0000_0010, 4'd7, 64'h8000_0000_0000_0010, 4'b0010);
      run("pass12", 64'hDEAD, 64'h1234, 4'd12, 64'h1234, 4'b0000);
      run("pass15_zero", 64'hFFFF, 64'd0, 4'd15, 64'd0, 4'b0100);
      bus.aluA = 64'd3;
      bus.aluB = 64'd4;
      bus.alufun = 4'd1;
      @(posedge clk);
      #1;
      bus.aluA = 64'hFF;
      bus.aluB = 64'h0F;
      bus.alufun = 4'd3;
      #2;
      check("lat_hold", bus.valE, 64'd7);
      @(posedge clk);
      #1;
      check("lat_next", bus.valE, 64'hF0);
      rst = 1'b1;
      bus.alufun = 4'd1;
      @(posedge clk);
      #1;
      check("rst_prio_valE", bus.valE, 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
